// File: rtl/int_div_sequencer.sv
// Multi-cycle integer DIV/DIVU/REM/REMU sequencer: restoring shift-subtract,
// one quotient bit per clock, valid/ready request and response ports.
module int_div_sequencer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  reqValid,
  output logic                  reqReady,
  input  logic [DATA_WIDTH-1:0] aOperand,
  input  logic [DATA_WIDTH-1:0] bOperand,
  input  logic                  unsignedEn,
  input  logic                  remSel,
  input  logic                  flush,
  output logic                  respValid,
  input  logic                  respReady,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  divByZero,
  output logic                  busy,
  output logic [2:0]            dbgState
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both 1; once respValid is up, result/divByZero hold until respReady.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ITER  = 3'd1,
    S_FIXUP = 3'd2,
    S_DZERO = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          r_state;
  logic [W-1:0]    r_rem;
  logic [W-1:0]    r_q;
  logic [W-1:0]    r_div;
  logic [W-1:0]    r_raw_a;
  logic [CW-1:0]   r_count;
  logic            r_q_neg;
  logic            r_r_neg;
  logic            r_rem_sel;
  logic            r_resp_valid;
  logic [W-1:0]    r_result;
  logic            r_div_by_zero;

  logic            w_accept;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [W-1:0]    w_a_abs;
  logic [W-1:0]    w_b_abs;
  logic [W:0]      w_rem_sh;
  logic            w_ge;
  logic [W-1:0]    w_sub;

  assign w_accept = reqValid && (r_state == S_IDLE) && !flush;
  assign w_a_neg  = !unsignedEn && aOperand[W-1];
  assign w_b_neg  = !unsignedEn && bOperand[W-1];
  assign w_a_abs  = w_a_neg ? (~aOperand + 1'b1) : aOperand;
  assign w_b_abs  = w_b_neg ? (~bOperand + 1'b1) : bOperand;

  // Partial remainder is always below the divisor, so the difference fits W bits.
  assign w_rem_sh = {r_rem, r_q[W-1]};
  assign w_ge     = (w_rem_sh >= {1'b0, r_div});
  assign w_sub    = w_rem_sh[W-1:0] - r_div;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_rem         <= '0;
      r_q           <= '0;
      r_div         <= '0;
      r_raw_a       <= '0;
      r_count       <= '0;
      r_q_neg       <= 1'b0;
      r_r_neg       <= 1'b0;
      r_rem_sel     <= 1'b0;
      r_resp_valid  <= 1'b0;
      r_result      <= '0;
      r_div_by_zero <= 1'b0;
    end else if (flush) begin
      r_state      <= S_IDLE;
      r_resp_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_rem     <= '0;
            r_q       <= w_a_abs;
            r_div     <= w_b_abs;
            r_raw_a   <= aOperand;
            r_q_neg   <= w_a_neg ^ w_b_neg;
            r_r_neg   <= w_a_neg;
            r_rem_sel <= remSel;
            r_count   <= CW'(W);
            r_state   <= (bOperand == '0) ? S_DZERO : S_ITER;
          end
        end
        S_ITER: begin
          r_rem   <= w_ge ? w_sub : w_rem_sh[W-1:0];
          r_q     <= {r_q[W-2:0], w_ge};
          r_count <= r_count - 1'b1;
          if (r_count == CW'(1)) begin
            r_state <= S_FIXUP;
          end
        end
        S_FIXUP: begin
          if (r_rem_sel) begin
            r_result <= r_r_neg ? (~r_rem + 1'b1) : r_rem;
          end else begin
            r_result <= r_q_neg ? (~r_q + 1'b1) : r_q;
          end
          r_div_by_zero <= 1'b0;
          r_state       <= S_DONE;
        end
        S_DZERO: begin
          r_result      <= r_rem_sel ? r_raw_a : '1;
          r_div_by_zero <= 1'b1;
          r_state       <= S_DONE;
        end
        S_DONE: begin
          // respValid rises on the first DONE cycle, giving registered timing.
          if (!r_resp_valid) begin
            r_resp_valid <= 1'b1;
          end else if (respReady) begin
            r_resp_valid <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_resp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign reqReady  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign respValid = r_resp_valid;
  assign result    = r_result;
  assign divByZero = r_div_by_zero;
  assign dbgState  = r_state;
endmodule

// File: tb/tb_int_div_sequencer.sv
// Directed bench for int_div_sequencer: vector table of ops with expected
// result/flag/latency, plus backpressure, flush and reset-abort sequences.
module tb_int_div_sequencer;
  localparam int W = 32;

  logic         clk;
  logic         reset_n;
  logic         reqValid;
  logic         reqReady;
  logic [W-1:0] aOperand;
  logic [W-1:0] bOperand;
  logic         unsignedEn;
  logic         remSel;
  logic         flush;
  logic         respValid;
  logic         respReady;
  logic [W-1:0] result;
  logic         divByZero;
  logic         busy;
  logic [2:0]   dbgState;

  int errors = 0;
  int checks = 0;

  int_div_sequencer #(.DATA_WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .reqValid(reqValid), .reqReady(reqReady),
    .aOperand(aOperand), .bOperand(bOperand), .unsignedEn(unsignedEn),
    .remSel(remSel), .flush(flush), .respValid(respValid),
    .respReady(respReady), .result(result), .divByZero(divByZero),
    .busy(busy), .dbgState(dbgState)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         u;
    logic         rs;
    logic [W-1:0] exp_res;
    logic         exp_dz;
    int           exp_lat;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one request; returns once the accept edge has passed.
  task automatic send_req(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic u, input logic rs);
    int n;
    aOperand   = a;
    bOperand   = b;
    unsignedEn = u;
    remSel     = rs;
    reqValid   = 1'b1;
    n = 0;
    while (!reqReady && n < 100) begin
      step();
      n++;
    end
    check("req_ready_wait", {31'd0, reqReady}, 32'd1);
    step();
    reqValid   = 1'b0;
    aOperand   = $urandom;
    bOperand   = $urandom;
    unsignedEn = 1'($urandom_range(0, 1));
    remSel     = 1'($urandom_range(0, 1));
  endtask

  // Waits for respValid and returns the cycle count from the accept edge.
  task automatic wait_resp(output int lat);
    lat = 0;
    for (int c = 1; c <= 100; c++) begin
      step();
      if (respValid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic run_op(input string name, input vec_t v);
    int lat;
    send_req(v.a, v.b, v.u, v.rs);
    wait_resp(lat);
    check({name, "_lat"}, lat, v.exp_lat);
    check({name, "_res"}, result, v.exp_res);
    check({name, "_dz"}, {31'd0, divByZero}, {31'd0, v.exp_dz});
    respReady = 1'b1;
    step();
    respReady = 1'b0;
    check({name, "_idle"}, {30'd0, respValid, reqReady}, 32'd1);
  endtask

  initial begin
    int lat;
    logic seen;
    vecs[0]  = '{32'd100, 32'd7, 1'b0, 1'b0, 32'd14, 1'b0, 34};
    vecs[1]  = '{32'd100, 32'd7, 1'b0, 1'b1, 32'd2, 1'b0, 34};
    vecs[2]  = '{32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, 32'hFFFFFFFD, 1'b0, 34};
    vecs[3]  = '{32'hFFFFFFF9, 32'd2, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 34};
    vecs[4]  = '{32'hFFFFFFFF, 32'd2, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b0, 34};
    vecs[5]  = '{32'hFFFFFFFF, 32'd2, 1'b1, 1'b1, 32'd1, 1'b0, 34};
    vecs[6]  = '{32'd5, 32'd0, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b1, 2};
    vecs[7]  = '{32'd5, 32'd0, 1'b0, 1'b1, 32'd5, 1'b1, 2};
    vecs[8]  = '{32'hFFFFFFF7, 32'd0, 1'b0, 1'b1, 32'hFFFFFFF7, 1'b1, 2};
    vecs[9]  = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h80000000, 1'b0, 34};
    vecs[10] = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1, 32'd0, 1'b0, 34};
    vecs[11] = '{32'h12345678, 32'h00001000, 1'b1, 1'b0, 32'h00012345, 1'b0, 34};
    vecs[12] = '{32'd7, 32'hFFFFFFFE, 1'b0, 1'b1, 32'd1, 1'b0, 34};

    reset_n = 1'b0; reqValid = 1'b0; aOperand = '0; bOperand = '0;
    unsignedEn = 1'b0; remSel = 1'b0; flush = 1'b0; respReady = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    step();
    check("rst_req_ready", {31'd0, reqReady}, 32'd1);
    check("rst_resp_valid", {31'd0, respValid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_dz", {31'd0, divByZero}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 13; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i]);
    end

    // Backpressure: result held 5 cycles, then back-to-back accept.
    send_req(32'd40, 32'd6, 1'b0, 1'b0);
    wait_resp(lat);
    check("bp_lat", lat, 34);
    for (int c = 0; c < 5; c++) begin
      step();
      check("bp_hold_res", result, 32'd6);
      check("bp_hold_flags", {29'd0, respValid, reqReady, divByZero}, 32'd4);
    end
    respReady = 1'b1;
    aOperand = 32'd9; bOperand = 32'd3; unsignedEn = 1'b0; remSel = 1'b0;
    reqValid = 1'b1;
    step();
    respReady = 1'b0;
    check("bp_release", {30'd0, respValid, reqReady}, 32'd1);
    step();
    reqValid = 1'b0;
    check("bp_b2b_busy", {31'd0, busy}, 32'd1);
    wait_resp(lat);
    check("bp_b2b_lat", lat, 34);
    check("bp_b2b_res", result, 32'd3);
    respReady = 1'b1;
    step();
    respReady = 1'b0;

    // Flush at ITER cycle 10: nothing emitted.
    send_req(32'd1000, 32'd3, 1'b1, 1'b0);
    repeat (10) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_idle", {30'd0, busy, reqReady}, 32'd1);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      step();
      seen = seen | respValid;
    end
    check("flush_no_resp", {31'd0, seen}, 32'd0);

    // flush wins over reqValid in IDLE.
    aOperand = 32'd8; bOperand = 32'd2; reqValid = 1'b1; flush = 1'b1;
    step();
    reqValid = 1'b0; flush = 1'b0;
    check("flush_no_accept", {31'd0, busy}, 32'd0);

    // Reset pulse mid-ITER, then a clean op.
    send_req(32'd77, 32'd5, 1'b0, 1'b0);
    repeat (5) step();
    reset_n = 1'b0;
    #2;
    check("rstmid_outs", {28'd0, respValid, divByZero, busy, reqReady}, 32'd1);
    check("rstmid_result", result, 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    step();
    run_op("post_rst", '{32'd9, 32'd3, 1'b0, 1'b0, 32'd3, 1'b0, 34});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
